// File: rtl/burst_arbiter.sv
// Two-requester round-robin burst arbiter feeding an accumulate-and-replay engine.
// Forwards up to MAX_LEN samples per burst and waits for the engine's OUT_VALID pulse.
module burst_arbiter #(
  parameter int unsigned MAX_LEN = 5,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       IN_VALID0,
  input  logic       IN_VALID1,
  input  logic [2:0] INPUT0,
  input  logic [2:0] INPUT1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       ENG_IN_VALID,
  output logic [2:0] ENG_INPUT,
  input  logic       ENG_OUT_VALID,
  output logic       DONE0,
  output logic       DONE1,
  output logic       OVF,
  output logic       ERR,
  output logic       BUSY
);

  localparam int unsigned DW = 3;
  localparam int unsigned CW = 3;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GRANT    = 3'd1;
  localparam logic [2:0] S_STREAM   = 3'd2;
  localparam logic [2:0] S_WAIT_ENG = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;

  logic [2:0]    state, state_nxt;
  logic          pri, pri_nxt;
  logic          sel, sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          seen, seen_nxt;
  logic          gnt0_nxt, gnt1_nxt, eiv_nxt, done0_nxt, done1_nxt;
  logic          ovf_nxt, err_nxt, busy_nxt;
  logic [DW-1:0] ein_nxt;

  logic          req_s, iv_s, win;
  logic [DW-1:0] in_s;

  // Granted requester's view; the other requester is ignored.
  always_comb begin
    req_s = sel ? REQ1 : REQ0;
    iv_s  = sel ? IN_VALID1 : IN_VALID0;
    in_s  = sel ? INPUT1 : INPUT0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state;
    pri_nxt   = pri;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    tmo_nxt   = tmo;
    seen_nxt  = seen;
    gnt0_nxt  = GNT0;
    gnt1_nxt  = GNT1;
    eiv_nxt   = 1'b0;
    ein_nxt   = '0;
    done0_nxt = 1'b0;
    done1_nxt = 1'b0;
    ovf_nxt   = OVF;
    err_nxt   = 1'b0;
    win       = 1'b0;

    if ((state == S_GRANT || state == S_STREAM) && iv_s) begin
      if (cnt == CW'(MAX_LEN)) begin
        ovf_nxt = 1'b1;
      end else begin
        eiv_nxt = 1'b1;
        ein_nxt = in_s;
        cnt_nxt = cnt + CW'(1);
      end
    end

    case (state)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          win       = (REQ0 && REQ1) ? pri : REQ1;
          sel_nxt   = win;
          gnt0_nxt  = !win;
          gnt1_nxt  = win;
          ovf_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (iv_s) begin
          state_nxt = S_STREAM;
        end else if (!req_s) begin
          gnt0_nxt  = 1'b0;
          gnt1_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        if (!iv_s) begin
          tmo_nxt   = '0;
          seen_nxt  = 1'b0;
          state_nxt = S_WAIT_ENG;
        end
      end
      S_WAIT_ENG: begin
        tmo_nxt = tmo + TW'(1);
        if (ENG_OUT_VALID) seen_nxt = 1'b1;
        if (seen && !ENG_OUT_VALID) begin
          done0_nxt = !sel;
          done1_nxt = sel;
          state_nxt = S_RELEASE;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          gnt0_nxt  = 1'b0;
          gnt1_nxt  = 1'b0;
          pri_nxt   = !sel;
          state_nxt = S_IDLE;
        end
      end
      S_RELEASE: begin
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        pri_nxt   = !sel;
        state_nxt = S_IDLE;
      end
      default: begin
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      pri          <= 1'b0;
      sel          <= 1'b0;
      cnt          <= '0;
      tmo          <= '0;
      seen         <= 1'b0;
      GNT0         <= 1'b0;
      GNT1         <= 1'b0;
      ENG_IN_VALID <= 1'b0;
      ENG_INPUT    <= '0;
      DONE0        <= 1'b0;
      DONE1        <= 1'b0;
      OVF          <= 1'b0;
      ERR          <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state        <= state_nxt;
      pri          <= pri_nxt;
      sel          <= sel_nxt;
      cnt          <= cnt_nxt;
      tmo          <= tmo_nxt;
      seen         <= seen_nxt;
      GNT0         <= gnt0_nxt;
      GNT1         <= gnt1_nxt;
      ENG_IN_VALID <= eiv_nxt;
      ENG_INPUT    <= ein_nxt;
      DONE0        <= done0_nxt;
      DONE1        <= done1_nxt;
      OVF          <= ovf_nxt;
      ERR          <= err_nxt;
      BUSY         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed self-checking bench for burst_arbiter: single bursts, round-robin,
// overflow, engine timeout, grant abort and asynchronous reset mid-burst.
module tb_burst_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ0, REQ1, IN_VALID0, IN_VALID1;
  logic [2:0] INPUT0, INPUT1;
  logic       GNT0, GNT1, ENG_IN_VALID;
  logic [2:0] ENG_INPUT;
  logic       ENG_OUT_VALID;
  logic       DONE0, DONE1, OVF, ERR, BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  burst_arbiter #(.MAX_LEN(5), .TIMEOUT(31)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1),
    .IN_VALID0(IN_VALID0), .IN_VALID1(IN_VALID1),
    .INPUT0(INPUT0), .INPUT1(INPUT1),
    .GNT0(GNT0), .GNT1(GNT1),
    .ENG_IN_VALID(ENG_IN_VALID), .ENG_INPUT(ENG_INPUT),
    .ENG_OUT_VALID(ENG_OUT_VALID),
    .DONE0(DONE0), .DONE1(DONE1),
    .OVF(OVF), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Both grants high together is never legal.
  always @(negedge CLK) begin
    n_assert++;
    assert (!(GNT0 === 1'b1 && GNT1 === 1'b1))
    else begin
      n_fail++;
      $error("FAIL both_gnt observed=%b%b expected=not 11", GNT0, GNT1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive n samples from the granted requester; first 5 are forwarded one cycle late.
  task automatic send(input int who, input int n, input int base);
    logic [2:0] d;
    for (int i = 0; i < n; i++) begin
      d = 3'(base + i);
      if (who == 0) begin IN_VALID0 = 1'b1; INPUT0 = d; end
      else          begin IN_VALID1 = 1'b1; INPUT1 = d; end
      tick();
      if (i < 5) begin
        chk("fwd_valid", 8'(ENG_IN_VALID), 8'd1);
        chk("fwd_data", 8'(ENG_INPUT), 8'(d));
      end else begin
        chk("drop_valid", 8'(ENG_IN_VALID), 8'd0);
        chk("ovf_set", 8'(OVF), 8'd1);
      end
    end
    IN_VALID0 = 1'b0; INPUT0 = 3'd0;
    IN_VALID1 = 1'b0; INPUT1 = 3'd0;
    tick();
    chk("end_valid", 8'(ENG_IN_VALID), 8'd0);
    chk("end_data", 8'(ENG_INPUT), 8'd0);
  endtask

  // Engine OUT_VALID high for k cycles, then low; the arbiter then sits in RELEASE.
  task automatic engine(input int k);
    ENG_OUT_VALID = 1'b1;
    repeat (k) tick();
    ENG_OUT_VALID = 1'b0;
    tick();
  endtask

  initial begin
    RST = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0; IN_VALID0 = 1'b0; IN_VALID1 = 1'b0;
    INPUT0 = 3'd0; INPUT1 = 3'd0; ENG_OUT_VALID = 1'b0;
    repeat (2) tick();
    chk("rst_gnt", 8'({GNT0, GNT1}), 8'd0);
    chk("rst_eng", 8'({ENG_IN_VALID, ENG_INPUT}), 8'd0);
    chk("rst_flags", 8'({DONE0, DONE1, OVF, ERR, BUSY}), 8'd0);
    #3 RST = 1'b0;

    // Single burst 1,2,3 from requester 0; sample coinciding with REQ rise is dropped.
    tick();
    REQ0 = 1'b1; IN_VALID0 = 1'b1; INPUT0 = 3'd7;
    tick();
    chk("t1_gnt0", 8'(GNT0), 8'd1);
    chk("t1_busy", 8'(BUSY), 8'd1);
    chk("t1_no_fwd_at_req", 8'(ENG_IN_VALID), 8'd0);
    IN_VALID0 = 1'b0;
    send(0, 3, 1);
    chk("t1_wait_done", 8'(DONE0), 8'd0);
    engine(4);
    chk("t1_done0", 8'({DONE0, DONE1}), 8'b10);
    chk("t1_gnt_in_release", 8'(GNT0), 8'd1);
    REQ0 = 1'b0;
    tick();
    chk("t1_done_pulse", 8'(DONE0), 8'd0);
    chk("t1_gnt0_low", 8'(GNT0), 8'd0);
    chk("t1_idle", 8'(BUSY), 8'd0);

    // Both request together right after reset: 0 first, then 1, then priority back to 0.
    #1 RST = 1'b1;
    #2 RST = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    chk("t2_first", 8'({GNT0, GNT1}), 8'b10);
    send(0, 2, 4);
    engine(2);
    chk("t2_done0", 8'({DONE0, DONE1}), 8'b10);
    REQ0 = 1'b0;
    tick();
    chk("t2_gap", 8'({GNT0, GNT1, DONE0}), 8'd0);
    tick();
    chk("t2_second", 8'({GNT0, GNT1}), 8'b01);
    send(1, 2, 1);
    engine(3);
    chk("t2_done1", 8'({DONE0, DONE1}), 8'b01);
    REQ1 = 1'b0;
    tick();
    chk("t2_gnt1_low", 8'(GNT1), 8'd0);
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    chk("t2_pri_back0", 8'({GNT0, GNT1}), 8'b10);

    // Requests dropped in GRANT before any data: no DONE, nothing forwarded, priority kept.
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    chk("t3_abort_gnt", 8'({GNT0, GNT1}), 8'd0);
    chk("t3_abort_flags", 8'({DONE0, DONE1, ENG_IN_VALID, BUSY}), 8'd0);
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    chk("t3_pri_kept", 8'({GNT0, GNT1}), 8'b10);
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();

    // Overflow: 7 samples from requester 1, only 5 forwarded.
    REQ1 = 1'b1;
    tick();
    chk("t4_gnt1", 8'(GNT1), 8'd1);
    chk("t4_ovf_clr", 8'(OVF), 8'd0);
    send(1, 7, 0);
    chk("t4_ovf_wait", 8'(OVF), 8'd1);
    engine(1);
    chk("t4_done1", 8'(DONE1), 8'd1);
    REQ1 = 1'b0;
    tick();
    chk("t4_ovf_sticky", 8'(OVF), 8'd1);
    chk("t4_gnt1_low", 8'(GNT1), 8'd0);

    // Engine never answers: ERR after 31 WAIT_ENG cycles; OVF cleared by the new grant.
    REQ0 = 1'b1;
    tick();
    chk("t5_gnt0", 8'(GNT0), 8'd1);
    chk("t5_ovf_clr", 8'(OVF), 8'd0);
    send(0, 1, 5);
    repeat (30) tick();
    chk("t5_no_err_yet", 8'({ERR, GNT0}), 8'b01);
    tick();
    chk("t5_err", 8'(ERR), 8'd1);
    chk("t5_gnt_low", 8'({GNT0, DONE0, BUSY}), 8'd0);
    REQ0 = 1'b0; REQ1 = 1'b1;
    tick();
    chk("t5_err_pulse", 8'(ERR), 8'd0);
    chk("t5_next_gnt", 8'({GNT0, GNT1}), 8'b01);

    // Reset during STREAM clears everything immediately; REQ1 then granted normally.
    IN_VALID1 = 1'b1; INPUT1 = 3'd3;
    tick();
    chk("t6_stream", 8'(ENG_IN_VALID), 8'd1);
    #1 RST = 1'b1;
    #1;
    chk("t6_rst_gnt", 8'({GNT0, GNT1}), 8'd0);
    chk("t6_rst_eng", 8'({ENG_IN_VALID, ENG_INPUT}), 8'd0);
    chk("t6_rst_flags", 8'({DONE0, DONE1, OVF, ERR, BUSY}), 8'd0);
    IN_VALID1 = 1'b0; INPUT1 = 3'd0;
    #2 RST = 1'b0;
    tick();
    chk("t6_regrant", 8'({GNT0, GNT1}), 8'b01);
    send(1, 1, 6);
    engine(2);
    chk("t6_done1", 8'({DONE0, DONE1}), 8'b01);
    REQ1 = 1'b0;
    tick();
    chk("t6_end", 8'({GNT1, DONE1, BUSY}), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_arbiter.md
BURST_ARBITER -- requirements
Module: burst_arbiter

Interface
REQ-001 Parameter MAX_LEN, default 5: maximum samples forwarded per burst, matching the accumulate-and-replay engine's storage.
REQ-002 Parameter TIMEOUT, default 31: cycles allowed in WAIT_ENG before abort.
REQ-003 Port CLK, input, 1: single clock; all state updates on rising edge.
REQ-004 Port RST, input, 1: reset, asynchronous, active-high.
REQ-005 Ports REQ0 / REQ1, input, 1 each: requester x asks to send a burst; held high until DONEx or ERR.
REQ-006 Ports IN_VALID0 / IN_VALID1, input, 1 each: sample valid from requester x.
REQ-007 Ports INPUT0 / INPUT1, input, 3 each: sample data from requester x.
REQ-008 Ports GNT0 / GNT1, output, 1 each: registered grant; at most one high at any time.
REQ-009 Port ENG_IN_VALID, output, 1: registered valid to the engine's IN_VALID.
REQ-010 Port ENG_INPUT, output, 3: registered data to the engine's INPUT.
REQ-011 Port ENG_OUT_VALID, input, 1: engine's OUT_VALID, observed to detect end of the replay+sum sequence.
REQ-012 Ports DONE0 / DONE1, output, 1 each: one-cycle pulse, burst of requester x fully processed.
REQ-013 Port OVF, output, 1: sticky per burst; burst exceeded MAX_LEN, excess dropped; cleared on next grant.
REQ-014 Port ERR, output, 1: one-cycle pulse, engine timeout.
REQ-015 Port BUSY, output, 1: high in every state except IDLE.

Function
REQ-016 States IDLE, GRANT, STREAM, WAIT_ENG, RELEASE, encoded in a registered state variable.
REQ-017 IDLE: if any REQ high, select winner, go to GRANT next cycle, with GNTx=1 from that cycle on; OVF cleared.
REQ-018 Arbitration is round-robin: pointer PRI names the preferred requester; single requester always wins; on both high, PRI wins; PRI toggles to the other requester on DONE or ERR of the served one.
REQ-019 GRANT: wait for granted IN_VALIDx=1 -> STREAM; if granted REQx drops first -> IDLE, GNT cleared, no DONE, PRI unchanged.
REQ-020 Forwarding in GRANT and STREAM: ENG_IN_VALID/ENG_INPUT equal granted IN_VALIDx/INPUTx delayed exactly one cycle; otherwise ENG_IN_VALID=0 and ENG_INPUT=0.
REQ-021 Sample counter (3 bits) counts forwarded samples; once count == MAX_LEN further samples are not forwarded (ENG_IN_VALID=0) and OVF is set.
REQ-022 STREAM: first cycle with granted IN_VALIDx=0 -> WAIT_ENG; non-granted IN_VALID/INPUT are ignored in all states.
REQ-023 WAIT_ENG: wait for ENG_OUT_VALID rise then fall; on the fall -> RELEASE.
REQ-024 WAIT_ENG timeout: cycle counter reaching TIMEOUT without completing rise+fall -> ERR pulse, GNT cleared, -> IDLE.
REQ-025 RELEASE (one cycle): DONEx=1, GNTx cleared at end of cycle, PRI toggled, -> IDLE; new grant no earlier than two cycles after DONE.
REQ-026 A REQ of the non-granted requester arriving mid-burst is held pending and served after RELEASE per REQ-018.
REQ-027 IN_VALIDx high in the same cycle as REQx rise is not forwarded (grant not yet issued).

Reset
REQ-028 RST=1 forces asynchronously: state IDLE, PRI=0, GNT0/1=0, ENG_IN_VALID=0, ENG_INPUT=0, DONE0/1=0, OVF=0, ERR=0, BUSY=0, counters 0.
REQ-029 RST mid-burst aborts with no DONE; after release first grant follows REQ-017 with PRI=0.

Verification
REQ-030 REQ0 only, burst 1,2,3 then engine OUT_VALID 4 cycles -> GNT0, ENG_INPUT 1,2,3 each one cycle late, DONE0 one pulse, GNT0 low next.
REQ-031 REQ0 and REQ1 same cycle after reset, two bursts -> REQ0 served first, REQ1 second, PRI back to 0; never both GNT high.
REQ-032 REQ1 burst of 7 samples -> exactly 5 ENG_IN_VALID pulses, OVF=1 until next grant, DONE1 issued.
REQ-033 Grant, burst sent, ENG_OUT_VALID never asserted -> ERR pulse after 31 WAIT_ENG cycles, GNT low, next request granted.
REQ-034 REQ0 dropped in GRANT before data -> return to IDLE, no DONE0, ENG_IN_VALID stays 0.
REQ-035 RST pulsed during STREAM -> all outputs 0 immediately; following REQ1 granted normally.
